// File: rtl/fc_tile_seq_if.sv
// Handshake bundle between the FC-layer sequencer, the IBUF, the CIM tile group and the
// function unit. The slave modport is the sequencer's view.
interface fc_tile_seq_if #(
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned NUM_ADDR  = 16,
  parameter int unsigned NUM_TILES = 4
);
  localparam int unsigned AW = (NUM_ADDR > 1) ? $clog2(NUM_ADDR) : 1;
  localparam int unsigned BW = $clog2(DATA_SIZE + 1);

  logic                 i_start;
  logic [BW-1:0]        i_num_bits;
  logic                 i_abort;
  logic                 o_ready;
  logic                 o_shift_enable;
  logic                 o_cim_we;
  logic [AW-1:0]        o_addr;
  logic [NUM_TILES-1:0] o_cim_start;
  logic [NUM_TILES-1:0] i_cim_ready;
  logic                 o_msb_plane;
  logic [BW-1:0]        o_bit_idx;
  logic                 i_func_ready;
  logic                 o_func_start;
  logic                 o_done;

  modport master (
    output i_start, i_num_bits, i_abort, i_cim_ready, i_func_ready,
    input  o_ready, o_shift_enable, o_cim_we, o_addr, o_cim_start, o_msb_plane, o_bit_idx,
           o_func_start, o_done
  );

  modport slave (
    input  i_start, i_num_bits, i_abort, i_cim_ready, i_func_ready,
    output o_ready, o_shift_enable, o_cim_we, o_addr, o_cim_start, o_msb_plane, o_bit_idx,
           o_func_start, o_done
  );
endinterface

// File: rtl/fc_tile_seq.sv
// FC-layer controller: loads bit-planes into all CIM tiles, starts them with per-tile
// ack tracking, repeats for each plane, then hands off to the function unit.
module fc_tile_seq #(
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned NUM_ADDR  = 16,
  parameter int unsigned NUM_TILES = 4
) (
  input logic          clk,
  input logic          rst,
  fc_tile_seq_if.slave bus_io
);
  localparam int unsigned AW = (NUM_ADDR > 1) ? $clog2(NUM_ADDR) : 1;
  localparam int unsigned BW = $clog2(DATA_SIZE + 1);
  localparam logic [AW-1:0] AddrLast = AW'(NUM_ADDR - 1);
  localparam logic [BW-1:0] BitsMax  = BW'(DATA_SIZE);

  typedef enum logic [2:0] {StIdle, StLoad, StStart, StWait, StDrain} state_e;

  state_e               state_q, state_d;
  logic                 pending_q, pending_d;
  logic [BW-1:0]        nb_q, nb_d;
  logic [BW-1:0]        bit_idx_q, bit_idx_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [NUM_TILES-1:0] ack_q, ack_d;
  logic                 shift_q, shift_d;
  logic                 func_q, func_d;

  logic          all_ready;
  logic          last_plane;
  logic [BW-1:0] nb_sel;

  assign all_ready  = &bus_io.i_cim_ready;
  assign last_plane = (bit_idx_q == nb_q - BW'(1));
  // Zero or out-of-range counts run the full plane count.
  assign nb_sel = (bus_io.i_num_bits == '0 || bus_io.i_num_bits > BitsMax) ?
                  BitsMax : bus_io.i_num_bits;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      pending_q <= 1'b0;
      nb_q      <= '0;
      bit_idx_q <= '0;
      addr_q    <= '0;
      ack_q     <= '0;
      shift_q   <= 1'b0;
      func_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      nb_q      <= nb_d;
      bit_idx_q <= bit_idx_d;
      addr_q    <= addr_d;
      ack_q     <= ack_d;
      shift_q   <= shift_d;
      func_q    <= func_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    nb_d      = nb_q;
    bit_idx_d = bit_idx_q;
    addr_d    = addr_q;
    ack_d     = ack_q;
    shift_d   = 1'b0;
    func_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus_io.i_start || pending_q) begin
          if (bus_io.i_start && !pending_q) nb_d = nb_sel;
          if (all_ready) begin
            state_d   = StLoad;
            pending_d = 1'b0;
          end else begin
            pending_d = 1'b1;
          end
        end
      end
      StLoad: begin
        addr_d = addr_q + AW'(1);
        if (addr_q == AddrLast) begin
          addr_d  = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        // A tile has acked once it has been seen busy; the mask is sticky.
        ack_d = ack_q | ~bus_io.i_cim_ready;
        if (&ack_d) begin
          ack_d   = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        if (all_ready) begin
          if (last_plane) begin
            state_d = StDrain;
          end else begin
            shift_d   = 1'b1;
            bit_idx_d = bit_idx_q + BW'(1);
            state_d   = StLoad;
          end
        end
      end
      StDrain: begin
        if (bus_io.i_func_ready) begin
          func_d    = 1'b1;
          bit_idx_d = '0;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (bus_io.i_abort) begin
      state_d   = StIdle;
      pending_d = 1'b0;
      nb_d      = '0;
      bit_idx_d = '0;
      addr_d    = '0;
      ack_d     = '0;
      shift_d   = 1'b0;
      func_d    = 1'b0;
    end
  end

  always_comb begin
    bus_io.o_ready        = (state_q == StIdle) && !pending_q;
    bus_io.o_cim_we       = (state_q == StLoad);
    bus_io.o_addr         = addr_q;
    bus_io.o_cim_start    = (state_q == StStart) ? ~ack_q : '0;
    bus_io.o_msb_plane    = (state_q inside {StLoad, StStart, StWait}) && last_plane;
    bus_io.o_bit_idx      = bit_idx_q;
    bus_io.o_shift_enable = shift_q;
    bus_io.o_func_start   = func_q;
    bus_io.o_done         = func_q;
  end
endmodule

// File: tb/tb_fc_tile_seq.sv
// Bench for fc_tile_seq: behavioural tile group and func unit, run-level expectations
// derived from the plane count and tile ack delays.
module tb_fc_tile_seq;
  localparam int unsigned DATA_SIZE = 8;
  localparam int unsigned NUM_ADDR  = 16;
  localparam int unsigned NUM_TILES = 4;
  localparam int unsigned AW = (NUM_ADDR > 1) ? $clog2(NUM_ADDR) : 1;
  localparam int unsigned BW = $clog2(DATA_SIZE + 1);
  localparam int unsigned VW = 6 + AW + NUM_TILES + BW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fc_tile_seq_if #(.DATA_SIZE(DATA_SIZE), .NUM_ADDR(NUM_ADDR), .NUM_TILES(NUM_TILES)) bus ();

  fc_tile_seq #(.DATA_SIZE(DATA_SIZE), .NUM_ADDR(NUM_ADDR), .NUM_TILES(NUM_TILES)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Tile model: ack delay after seeing start, then busy for busy_len cycles.
  int dly[NUM_TILES];
  int ph[NUM_TILES];
  int cnt[NUM_TILES];
  int rem[NUM_TILES];
  int busy_len = 2;

  int nb_exp, bursts, we_cnt, burst_len, addr_err, msb_err, shift_cnt, shift_hi;
  int func_cnt, done_cnt, pulse_err, start_err, rises, first_we, exp_load, cs_cyc;
  int hi_len[NUM_TILES];
  bit arm = 1'b0;
  bit chk_on = 1'b1;
  logic prev_we = 1'b0;
  logic prev_shift = 1'b0;
  logic [NUM_TILES-1:0] prev_start = '0;

  function automatic bit tiles_idle();
    for (int t = 0; t < NUM_TILES; t++) if (ph[t] != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [VW-1:0] out_vec();
    return {bus.o_ready, bus.o_cim_we, bus.o_addr, bus.o_cim_start, bus.o_shift_enable,
            bus.o_msb_plane, bus.o_bit_idx, bus.o_func_start, bus.o_done};
  endfunction

  task automatic observe();
    logic [NUM_TILES-1:0] cs;
    cs = bus.o_cim_start;
    if (arm && exp_load < 0 && (&bus.i_cim_ready)) begin
      exp_load = cyc;
      arm = 1'b0;
    end
    if (bus.o_cim_we) begin
      if (!prev_we) begin
        bursts++;
        burst_len = 0;
        if (first_we < 0) first_we = cyc;
      end
      if (int'(bus.o_addr) != burst_len) addr_err++;
      if (int'(bus.o_bit_idx) != bursts - 1) msb_err++;
      if (bus.o_msb_plane !== (bursts == nb_exp)) msb_err++;
      burst_len++;
      we_cnt++;
    end else if (prev_we && burst_len != NUM_ADDR) begin
      addr_err++;
    end
    if (bus.o_ready && bus.o_msb_plane) msb_err++;
    if (bus.o_shift_enable) begin
      shift_hi++;
      if (!prev_shift) shift_cnt++;
    end
    if (bus.o_func_start) begin
      func_cnt++;
      if (!bus.i_func_ready) pulse_err++;
    end
    if (bus.o_done) done_cnt++;
    if (bus.o_done !== bus.o_func_start) pulse_err++;
    if (prev_start == '0 && cs != '0) begin
      rises++;
      if (chk_on && cs != '1) start_err++;
    end
    for (int t = 0; t < NUM_TILES; t++) begin
      if (cs[t]) hi_len[t]++;
      else if (prev_start[t]) begin
        if (chk_on && hi_len[t] != dly[t] + 1) start_err++;
        hi_len[t] = 0;
      end
    end
    prev_start = cs;
    prev_we    = bus.o_cim_we;
    prev_shift = bus.o_shift_enable;
  endtask

  task automatic tiles_drive();
    logic [NUM_TILES-1:0] r;
    for (int t = 0; t < NUM_TILES; t++) begin
      if (ph[t] == 0 && bus.o_cim_start[t]) begin
        ph[t]  = 1;
        cnt[t] = dly[t];
      end
      if (ph[t] == 1) begin
        if (cnt[t] == 0) begin
          ph[t]  = 2;
          rem[t] = busy_len;
        end else cnt[t]--;
      end
      if (ph[t] == 2) begin
        r[t] = 1'b0;
        rem[t]--;
        if (rem[t] == 0) ph[t] = 0;
      end else r[t] = 1'b1;
    end
    bus.i_cim_ready = r;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    observe();
    tiles_drive();
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (!(bus.o_ready && tiles_idle() && (&bus.i_cim_ready)) && k < 500) begin
      step();
      k++;
    end
    if (k >= 500) begin
      total++;
      bad++;
      $display("FAIL %s idle_timeout: waited %0d cycles, limit 500", name, k);
    end
  endtask

  task automatic issue(input string name, input int n);
    nb_exp = (n == 0 || n > int'(DATA_SIZE)) ? int'(DATA_SIZE) : n;
    bursts = 0; we_cnt = 0; burst_len = 0; addr_err = 0; msb_err = 0; shift_cnt = 0;
    shift_hi = 0; func_cnt = 0; done_cnt = 0; pulse_err = 0; start_err = 0; rises = 0;
    first_we = -1; exp_load = -1;
    for (int t = 0; t < NUM_TILES; t++) hi_len[t] = 0;
    bus.i_start    = 1'b1;
    bus.i_num_bits = BW'(n);
    cs_cyc = cyc;
    arm = 1'b1;
    step();
    bus.i_start    = 1'b0;
    bus.i_num_bits = BW'($urandom);
    total++;
    if (bus.o_ready !== 1'b0)
      begin bad++; $display("FAIL %s ready_drop: got %b want 0", name, bus.o_ready); end
  endtask

  task automatic do_run(input string name, input int n, input bit pre2, input int fr_hold);
    int k, hold, rcyc, fs_cyc;
    wait_idle(name);
    if (pre2) begin
      ph[2] = 2;
      rem[2] = 9;
      bus.i_cim_ready[2] = 1'b0;
    end
    bus.i_func_ready = (fr_hold == 0);
    issue(name, n);
    k = 0; hold = 0; rcyc = -1; fs_cyc = -1;
    while (!bus.o_done && k < 4000) begin
      step();
      k++;
      if (bus.o_done) fs_cyc = cyc;
      else if (!bus.i_func_ready && rises == nb_exp && bus.o_cim_start == '0 &&
               (&bus.i_cim_ready)) begin
        hold++;
        if (hold > fr_hold) begin
          bus.i_func_ready = 1'b1;
          rcyc = cyc;
        end
      end
    end
    total++;
    if (fs_cyc < 0) begin bad++; $display("FAIL %s done_timeout: got none in %0d cycles", name, k); end
    total++;
    if (first_we != exp_load)
      begin bad++; $display("FAIL %s load_latency: got %0d want %0d", name, first_we, exp_load); end
    total++;
    if (bursts != nb_exp)
      begin bad++; $display("FAIL %s planes: got %0d want %0d", name, bursts, nb_exp); end
    total++;
    if (we_cnt != nb_exp * NUM_ADDR)
      begin bad++; $display("FAIL %s we_cycles: got %0d want %0d", name, we_cnt, nb_exp * NUM_ADDR); end
    total++;
    if (addr_err != 0) begin bad++; $display("FAIL %s addr_seq: got %0d errors want 0", name, addr_err); end
    total++;
    if (msb_err != 0) begin bad++; $display("FAIL %s msb_idx: got %0d errors want 0", name, msb_err); end
    total++;
    if (shift_cnt != nb_exp - 1 || shift_hi != nb_exp - 1)
      begin bad++; $display("FAIL %s shifts: got %0d pulses %0d cycles want %0d", name, shift_cnt, shift_hi, nb_exp - 1); end
    total++;
    if (func_cnt != 1 || done_cnt != 1)
      begin bad++; $display("FAIL %s func_done: got %0d/%0d want 1/1", name, func_cnt, done_cnt); end
    total++;
    if (pulse_err != 0) begin bad++; $display("FAIL %s func_pulse: got %0d errors want 0", name, pulse_err); end
    total++;
    if (start_err != 0 || rises != nb_exp)
      begin bad++; $display("FAIL %s cim_start: got %0d errors %0d rises want 0 %0d", name, start_err, rises, nb_exp); end
    if (rcyc >= 0) begin
      total++;
      if (fs_cyc != rcyc + 1)
        begin bad++; $display("FAIL %s func_latency: got %0d want %0d", name, fs_cyc, rcyc + 1); end
    end
    if (pre2) begin
      total++;
      if (first_we - cs_cyc != 11)
        begin bad++; $display("FAIL %s queued_load: got %0d want 11", name, first_we - cs_cyc); end
    end
    step();
    total++;
    if (bus.o_ready !== 1'b1 || bus.o_done !== 1'b0)
      begin bad++; $display("FAIL %s after_done: got ready=%b done=%b want 1 0", name, bus.o_ready, bus.o_done); end
  endtask

  task automatic set_dly(input int d0, input int d1, input int d2, input int d3, input int b);
    dly[0] = d0; dly[1] = d1; dly[2] = d2; dly[3] = d3;
    busy_len = b;
  endtask

  task automatic test_reset();
    logic [VW-1:0] exp_v;
    exp_v = '0;
    exp_v[VW-1] = 1'b1;
    rst = 1'b1;
    bus.i_start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (out_vec() !== exp_v) begin bad++; $display("FAIL reset_outputs: got %h want %h", out_vec(), exp_v); end
    total++;
    if (bus.o_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", bus.o_ready); end
    bus.i_start = 1'b0;
    rst = 1'b0;
    step();
    total++;
    if (out_vec() !== exp_v) begin bad++; $display("FAIL reset_release: got %h want %h", out_vec(), exp_v); end
  endtask

  task automatic test_nominal();
    set_dly(3, 3, 3, 3, 2);
    do_run("nominal", 8, 1'b0, 0);
  endtask

  task automatic test_queued();
    set_dly(2, 2, 2, 2, 2);
    do_run("queued", 5, 1'b1, 0);
  endtask

  task automatic test_skewed();
    set_dly(1, 4, 7, 2, 3);
    do_run("skewed", 2, 1'b0, 0);
  endtask

  task automatic test_clamp();
    set_dly(0, 1, 0, 2, 1);
    do_run("clamp0", 0, 1'b0, 0);
    do_run("clamp3", 3, 1'b0, 0);
    do_run("one_plane", 1, 1'b0, 0);
    do_run("clamp_hi", 13, 1'b0, 0);
  endtask

  task automatic test_backpressure();
    set_dly(2, 1, 3, 0, 2);
    do_run("func_bp", 2, 1'b0, 20);
  endtask

  task automatic test_abort();
    logic [VW-1:0] exp_v;
    int k;
    exp_v = '0;
    exp_v[VW-1] = 1'b1;
    set_dly(1, 1, 1, 1, 2);
    chk_on = 1'b0;
    wait_idle("abort");
    bus.i_func_ready = 1'b1;
    issue("abort_load", 4);
    k = 0;
    while (!(bus.o_cim_we && bus.o_addr == AW'(5)) && k < 100) begin step(); k++; end
    bus.i_abort = 1'b1;
    step();
    bus.i_abort = 1'b0;
    total++;
    if (k >= 100 || out_vec() !== exp_v)
      begin bad++; $display("FAIL abort_load: got %h want %h (wait %0d)", out_vec(), exp_v, k); end
    bus.i_start = 1'b1;
    bus.i_abort = 1'b1;
    step();
    bus.i_start = 1'b0;
    bus.i_abort = 1'b0;
    total++;
    if (bus.o_ready !== 1'b1 || bus.o_cim_we !== 1'b0)
      begin bad++; $display("FAIL abort_start_ignored: got ready=%b we=%b want 1 0", bus.o_ready, bus.o_cim_we); end
    func_cnt = 0;
    we_cnt = 0;
    repeat (40) step();
    total++;
    if (func_cnt != 0 || we_cnt != 0)
      begin bad++; $display("FAIL abort_quiet: got func=%0d we=%0d want 0 0", func_cnt, we_cnt); end
    wait_idle("abort");
    issue("abort_start", 4);
    k = 0;
    while (bus.o_cim_start == '0 && k < 100) begin step(); k++; end
    bus.i_abort = 1'b1;
    step();
    bus.i_abort = 1'b0;
    total++;
    if (k >= 100 || out_vec() !== exp_v)
      begin bad++; $display("FAIL abort_start: got %h want %h (wait %0d)", out_vec(), exp_v, k); end
    chk_on = 1'b1;
    do_run("after_abort", 5, 1'b0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      for (int t = 0; t < NUM_TILES; t++) dly[t] = int'($urandom_range(0, 5));
      busy_len = int'($urandom_range(1, 4));
      do_run("random", int'($urandom_range(0, 12)), 1'b0,
             ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 8)) : 0);
    end
  endtask

  initial begin
    for (int t = 0; t < NUM_TILES; t++) begin
      ph[t] = 0; cnt[t] = 0; rem[t] = 0; dly[t] = 1; hi_len[t] = 0;
    end
    bus.i_start      = 1'b0;
    bus.i_num_bits   = '0;
    bus.i_abort      = 1'b0;
    bus.i_cim_ready  = '1;
    bus.i_func_ready = 1'b1;
    test_reset();
    test_nominal();
    test_queued();
    test_skewed();
    test_clamp();
    test_backpressure();
    test_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
